keypad_entry: RTL and testbench

Keypad digit-entry buffer directly downstream of the synchronized keypad encoder. It consumes the encoder's 5-bit key index and level-high strobe, and turns each new key press into exactly one event. Digit keys build a hex number in a shift register; command keys enter, backspace or clear that number. The latched value and a one-cycle valid pulse feed the datapath and display logic.

---
 rtl/keypad_entry.sv | 97 +++++++++
 tb/tb_keypad_entry.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad digit-entry buffer: turns each new key press into one event that appends,
// removes, clears or latches a right-justified hex number.
module keypad_entry #(
    parameter int NDIGITS = 8,
    parameter int CW      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             keycode,
    input  logic                   strobe,
    output logic [4*NDIGITS-1:0]   entry,
    output logic [CW-1:0]          ndig,
    output logic                   full,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   valid
);

    localparam int            EW   = 4 * NDIGITS;
    localparam logic [CW-1:0] NMAX = CW'(NDIGITS);

    localparam logic [4:0] KEY_ENTER = 5'd16;
    localparam logic [4:0] KEY_BKSP  = 5'd17;
    localparam logic [4:0] KEY_CLEAR = 5'd18;

    function automatic logic [EW-1:0] push_digit(input logic [EW-1:0] cur, input logic [3:0] d);
        return {cur[EW-5:0], d};
    endfunction

    function automatic logic [EW-1:0] drop_digit(input logic [EW-1:0] cur);
        return {4'h0, cur[EW-1:4]};
    endfunction

    logic          strobe_q;
    logic          key_evt;
    logic [EW-1:0] entry_nxt;
    logic [CW-1:0] ndig_nxt;
    logic [EW-1:0] value_nxt;
    logic          valid_nxt;

    // strobe_q resets high so a key held through reset cannot fire an event.
    assign key_evt = strobe & ~strobe_q;

    always_comb begin
        entry_nxt = entry;
        ndig_nxt  = ndig;
        value_nxt = value;
        valid_nxt = 1'b0;
        if (key_evt) begin
            if (!keycode[4]) begin
                if (ndig != NMAX) begin
                    entry_nxt = push_digit(entry, keycode[3:0]);
                    ndig_nxt  = ndig + 1'b1;
                end
            end else begin
                case (keycode)
                    KEY_ENTER: begin
                        value_nxt = entry;
                        entry_nxt = '0;
                        ndig_nxt  = '0;
                        valid_nxt = 1'b1;
                    end
                    KEY_BKSP: begin
                        if (ndig != '0) begin
                            entry_nxt = drop_digit(entry);
                            ndig_nxt  = ndig - 1'b1;
                        end
                    end
                    KEY_CLEAR: begin
                        entry_nxt = '0;
                        ndig_nxt  = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register stage: all outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b1;
            entry    <= '0;
            ndig     <= '0;
            full     <= 1'b0;
            value    <= '0;
            valid    <= 1'b0;
        end else begin
            strobe_q <= strobe;
            entry    <= entry_nxt;
            ndig     <= ndig_nxt;
            full     <= (ndig_nxt == NMAX);
            value    <= value_nxt;
            valid    <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized bench for keypad_entry: a digit-queue reference model plus directed
// checkpoints for the documented press sequences.
module tb_keypad_entry;

    localparam int NDIGITS = 8;
    localparam int CW      = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [4:0]           keycode;
    logic                 strobe;
    logic [4*NDIGITS-1:0] entry;
    logic [CW-1:0]        ndig;
    logic                 full;
    logic [4*NDIGITS-1:0] value;
    logic                 valid;

    keypad_entry #(.NDIGITS(NDIGITS), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .keycode (keycode),
        .strobe  (strobe),
        .entry   (entry),
        .ndig    (ndig),
        .full    (full),
        .value   (value),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: digits held oldest-first in a queue.
    int unsigned m_digits[$];
    longint      m_value = 0;
    bit          m_valid = 0;
    bit          m_prev  = 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model_entry();
        longint e = 0;
        foreach (m_digits[i]) e = e * 16 + longint'(m_digits[i]);
        return e;
    endfunction

    function automatic void model_key(input int code);
        if (code < 16) begin
            if (m_digits.size() < NDIGITS) m_digits.push_back(code);
        end else if (code == 16) begin
            m_value = model_entry();
            m_digits.delete();
            m_valid = 1;
        end else if (code == 17) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
        end else if (code == 18) begin
            m_digits.delete();
        end
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_digits.delete();
            m_value = 0;
            m_valid = 0;
            m_prev  = 1;
        end else begin
            m_valid = 0;
            if (strobe && !m_prev) model_key(int'(keycode));
            m_prev = strobe;
        end
        #1;
        chk("entry", 64'(entry), 64'(model_entry()));
        chk("ndig",  64'(ndig),  64'(m_digits.size()));
        chk("full",  64'(full),  64'(m_digits.size() == NDIGITS));
        chk("value", 64'(value), 64'(m_value));
        chk("valid", 64'(valid), 64'(m_valid));
    endtask

    task automatic press(input int code, input int hi, input int lo);
        keycode = 5'(code);
        strobe  = 1'b1;
        repeat (hi) tick();
        strobe = 1'b0;
        repeat (lo) tick();
    endtask

    int valid_seen;

    initial begin
        rst = 1'b1; strobe = 1'b0; keycode = '0;
        repeat (2) tick();
        chk("rst_entry", 64'(entry), 64'h0);
        chk("rst_ndig",  64'(ndig),  64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        rst = 1'b0;
        tick();

        // 1,2,3 -> 0x123, never valid
        valid_seen = 0;
        for (int k = 1; k <= 3; k++) begin
            keycode = 5'(k); strobe = 1'b1;
            repeat (3) begin tick(); valid_seen += int'(valid); end
            strobe = 1'b0;
            repeat (2) begin tick(); valid_seen += int'(valid); end
        end
        chk("tp1_entry", 64'(entry), 64'h123);
        chk("tp1_ndig",  64'(ndig),  64'd3);
        chk("tp1_full",  64'(full),  64'd0);
        chk("tp1_novalid", 64'(valid_seen), 64'd0);

        // long hold with keycode change -> single digit
        press(18, 1, 1);
        keycode = 5'd5; strobe = 1'b1;
        repeat (10) tick();
        keycode = 5'd7;
        repeat (3) tick();
        strobe = 1'b0;
        repeat (2) tick();
        chk("hold_entry", 64'(entry), 64'h5);
        chk("hold_ndig",  64'(ndig),  64'd1);

        // fill to 8 digits, overflow ignored, ENTER latches
        press(18, 1, 1);
        for (int k = 1; k <= 8; k++) press(k, 2, 1);
        chk("full_entry", 64'(entry), 64'h12345678);
        chk("full_ndig",  64'(ndig),  64'd8);
        chk("full_flag",  64'(full),  64'd1);
        press(9, 2, 1);
        chk("ovf_entry", 64'(entry), 64'h12345678);
        chk("ovf_ndig",  64'(ndig),  64'd8);
        keycode = 5'd16; strobe = 1'b1;
        tick();
        chk("ent_valid", 64'(valid), 64'd1);
        chk("ent_value", 64'(value), 64'h12345678);
        tick();
        chk("ent_pulse1", 64'(valid), 64'd0);
        strobe = 1'b0; tick();
        chk("ent_entry", 64'(entry), 64'h0);
        chk("ent_full",  64'(full),  64'd0);

        // backspace, underflow guard, ENTER in EMPTY
        press(10, 1, 1); press(11, 1, 1);
        chk("ab_entry", 64'(entry), 64'hAB);
        press(17, 2, 1);
        chk("bs_entry", 64'(entry), 64'hA);
        chk("bs_ndig",  64'(ndig),  64'd1);
        press(17, 2, 1); press(17, 2, 1);
        chk("bs0_entry", 64'(entry), 64'h0);
        chk("bs0_ndig",  64'(ndig),  64'd0);
        keycode = 5'd16; strobe = 1'b1;
        tick();
        chk("empty_valid", 64'(valid), 64'd1);
        chk("empty_value", 64'(value), 64'h0);
        strobe = 1'b0; tick();

        // CLEAR keeps value; code 19 ignored
        press(4, 1, 1); press(16, 1, 1);
        chk("v4_value", 64'(value), 64'h4);
        press(9, 1, 1); press(18, 2, 2);
        chk("clr_entry", 64'(entry), 64'h0);
        chk("clr_value", 64'(value), 64'h4);
        press(2, 1, 1); press(19, 2, 2);
        chk("k19_entry", 64'(entry), 64'h2);

        // reset with key held
        press(1, 1, 1); press(2, 1, 1); press(3, 1, 1);
        keycode = 5'd6; strobe = 1'b1;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("hrst_entry", 64'(entry), 64'h0);
        chk("hrst_value", 64'(value), 64'h0);
        repeat (4) tick();
        chk("hrst_noevt", 64'(entry), 64'h0);
        strobe = 1'b0; tick();
        press(6, 2, 1);
        chk("hrst_after", 64'(entry), 64'h6);

        // randomized presses
        for (int n = 0; n < 1500; n++) begin
            int code;
            int sel;
            int hi;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       code = int'($urandom_range(0, 15));
            else if (sel < 8)  code = int'($urandom_range(16, 18));
            else               code = int'($urandom_range(0, 31));
            hi = int'($urandom_range(1, 4));
            keycode = 5'(code); strobe = 1'b1;
            tick();
            if (hi > 1) begin
                if ($urandom_range(0, 3) == 0) keycode = 5'($urandom_range(0, 31));
                repeat (hi - 1) tick();
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            strobe = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
